pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter and next-address sequencer for the SELTEN CPU datapath, replacing the fixed 19-bit PC logic inside the datapath unit. It selects sequential, jump, conditional-branch, call and return addresses from decoded control strobes. Return addresses live on a hardware stack of configurable depth, with sticky overflow and underflow error flags. It sits between the control unit (strobes) and instruction memory (`pc_current`).

## Interface
- `PC_W`, 19, PC width in bits.
- `RAS_DEPTH`, 8, return-address stack entries (≥2).
- `RESET_VECTOR`, 0, PC value on reset.
- `PC_INC`, 1, sequential increment (instruction-addressed memory).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hold all state; strobes ignored.
- `jump`  in  1  unconditional jump to `target`.
- `beq`  in  1  branch if `zero`=1.
- `bne`  in  1  branch if `zero`=0.
- `call`  in  1  push return address, jump to `target`.
- `ret`  in  1  pop return address into PC.
- `zero`  in  1  ALU zero flag for the current instruction.
- `target`  in  PC_W  absolute jump/call address.
- `offset`  in  PC_W  two's-complement branch offset.
- `err_clr`  in  1  clears both sticky error flags.
- `pc_current`  out  PC_W  registered PC.
- `pc_next`  out  PC_W  combinational preview of next PC.
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid stack entries.
- `ras_overflow`  out  1  sticky: call while stack full.
- `ras_underflow`  out  1  sticky: ret while stack empty.

## Operation
- Reset: `pc_current`=RESET_VECTOR, `ras_count`=0, both flags 0. Stack RAM contents are not reset and are not observable while empty.
- Strobe priority: `ret` > `call` > `jump` > `beq`/`bne`. Lower-priority strobes asserted in the same cycle are ignored.
- `seq` = `pc_current` + PC_INC, modulo 2^PC_W.
- `ret`, count>0: pop; PC = top entry; count−1.
- `ret`, count=0: PC = `seq`; underflow set; count stays 0.
- `call`, count<RAS_DEPTH: push `seq`; PC = `target`; count+1.
- `call`, count=RAS_DEPTH: behaviour depends on Configuration; PC = `target` in all cases.
- `jump`: PC = `target`.
- Branch taken = (`beq`&`zero`)|(`bne`&~`zero`). Taken: PC = `seq` + `offset`, modulo 2^PC_W; wraps silently in both directions. Not taken: PC = `seq`.
- No strobe: PC = `seq`. The PC wraps from 2^PC_W−1 to 0.
- `stall`=1: PC, stack, count and flags hold. `err_clr` is also ignored.
- `err_clr`: clears both flags next edge. A same-cycle new error wins: the flag is set.
- `pc_next` always equals the value `pc_current` takes on the next unstalled edge.

## Timing
- All state updates on rising `clk`. Strobes are sampled in cycle N; the new `pc_current` appears after edge N+1. This is single-cycle latency with no bubbles.
- Back-to-back call/ret every cycle is supported. A ret immediately after a call returns the just-pushed address.
- `pc_next` is combinational from the strobes, `zero`, `target`, `offset` and stack top. There is no registered path from inputs to `pc_next`.
- `rst_n` assertion takes effect immediately, including mid-stall or mid-call. Deassertion is synchronous to `clk` by the system reset synchroniser.

## Configuration
- `PC_RAS_WRAP_EN` defined: the stack is circular. A call when full overwrites the oldest entry and pushes `seq`; count stays RAS_DEPTH; `ras_overflow` is set.
- `PC_RAS_WRAP_EN` undefined: a call when full discards the push, leaving stack contents unchanged; count stays RAS_DEPTH; `ras_overflow` is set.

## Test plan
- Reset then 3 free-running cycles (PC_W=19, RESET_VECTOR=0) -> `pc_current` 0,1,2,3. Force PC=0x7FFFF (via jump), one cycle -> 0x00000.
- At PC=10, `call` target=100 -> PC=100, count=1. Then `ret` -> PC=11, count=0. Then `ret` again -> PC=12, underflow=1. Then `err_clr` -> underflow=0.
- At PC=20, `beq` offset=−5 (0x7FFFB): with zero=1 -> PC=16; with zero=0 -> PC=21. `bne` offset=4 with zero=0 -> PC = seq+4.
- `ret`+`call`+`jump` asserted together with count=2 -> pop only; count=1; `target` ignored.
- RAS_DEPTH=4: 5 nested calls from PCs 0,10,20,30,40 -> overflow=1, count=4. 5 rets: undefined macro -> 31,21,11,1 then underflow; `PC_RAS_WRAP_EN` -> 41,31,21,11 then underflow.
- `stall` held 3 cycles with `call` asserted -> PC, count and flags unchanged. `rst_n` pulsed mid-sequence -> PC=RESET_VECTOR, count=0 asynchronously.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control-unit strobes in, PC and return-stack status out.
interface pc_sequencer_if #(
  parameter int PC_W      = 19,
  parameter int RAS_DEPTH = 8
);
  logic                               stall, jump, beq, bne, call, ret, zero, err_clr;
  logic [PC_W-1:0]                    target, offset;
  logic [PC_W-1:0]                    pc_current, pc_next;
  logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count;
  logic                               ras_overflow, ras_underflow;
  modport master (
    output stall, jump, beq, bne, call, ret, zero, err_clr, target, offset,
    input  pc_current, pc_next, ras_count, ras_overflow, ras_underflow
  );
  modport slave (
    input  stall, jump, beq, bne, call, ret, zero, err_clr, target, offset,
    output pc_current, pc_next, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC and next-address selection with a return-address stack.
// Define PC_RAS_WRAP_EN to make the stack circular (a call when full overwrites the oldest entry).
module pc_sequencer #(
  parameter int PC_W         = 19,
  parameter int RAS_DEPTH    = 8,
  parameter int RESET_VECTOR = 0,
  parameter int PC_INC       = 1
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int AW = $clog2(RAS_DEPTH);
  logic [PC_W-1:0] pc, seq, top, nxt;
  logic [PC_W-1:0] stk [RAS_DEPTH];
  logic [AW-1:0]   ptr, ptr_inc, ptr_dec;
  logic [CW-1:0]   cnt;
  logic            ovf, unf, empty, full, taken, pop, push, do_call;
  assign seq     = pc + PC_W'(PC_INC);
  assign empty   = cnt == '0;
  assign full    = cnt == CW'(RAS_DEPTH);
  assign ptr_inc = (ptr == AW'(RAS_DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign ptr_dec = (ptr == '0) ? AW'(RAS_DEPTH - 1) : ptr - 1'b1;
  assign top     = stk[ptr_dec];
  assign taken   = (bus.beq & bus.zero) | (bus.bne & ~bus.zero);
  assign pop     = bus.ret & ~empty;
  assign do_call = bus.call & ~bus.ret;
`ifdef PC_RAS_WRAP_EN
  assign push    = do_call;
`else
  assign push    = do_call & ~full;
`endif
  // ret > call > jump > branch
  always_comb begin
    nxt = bus.ret ? (empty ? seq : top) :
          (bus.call | bus.jump) ? bus.target :
          taken ? seq + bus.offset : seq;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= PC_W'(RESET_VECTOR);
      cnt <= '0;
      ptr <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (!bus.stall) begin
      pc  <= nxt;
      if (push) ptr <= ptr_inc;
      else if (pop) ptr <= ptr_dec;
      if (push && !full) cnt <= cnt + 1'b1;
      else if (pop) cnt <= cnt - 1'b1;
      ovf <= (ovf & ~bus.err_clr) | (do_call & full);
      unf <= (unf & ~bus.err_clr) | (bus.ret & empty);
    end
  end
  // stack storage is deliberately unreset; entries are only read while valid
  always_ff @(posedge clk) begin
    if (!bus.stall && push) stk[ptr] <= seq;
  end
  assign bus.pc_current    = pc;
  assign bus.pc_next       = nxt;
  assign bus.ras_count     = cnt;
  assign bus.ras_overflow  = ovf;
  assign bus.ras_underflow = unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus async-reset and stack-overflow sequences.
module tb_pc_sequencer;
  localparam int PC_W = 19;
  localparam int DEPTH = 4;
`ifdef PC_RAS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  typedef struct {
    logic st, r, c, j, bq, bn, z, clr;
    logic [PC_W-1:0] tgt, off, pc;
    logic [2:0] cnt;
    logic ovf, unf;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  vec_t t1[$];
  vec_t t2[$];
  pc_sequencer_if #(.PC_W(PC_W), .RAS_DEPTH(DEPTH)) bus();
  pc_sequencer #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .RESET_VECTOR(0), .PC_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic st, logic r, logic c, logic j, logic bq, logic bn, logic z,
                              logic clr, int tgt, int off, int pc, int cnt, logic ovf, logic unf);
    vec_t v;
    v.st = st; v.r = r; v.c = c; v.j = j; v.bq = bq; v.bn = bn; v.z = z; v.clr = clr;
    v.tgt = PC_W'(tgt); v.off = PC_W'(off); v.pc = PC_W'(pc); v.cnt = 3'(cnt);
    v.ovf = ovf; v.unf = unf;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic drive(input vec_t v);
    bus.stall = v.st; bus.ret = v.r; bus.call = v.c; bus.jump = v.j;
    bus.beq = v.bq; bus.bne = v.bn; bus.zero = v.z; bus.err_clr = v.clr;
    bus.target = v.tgt; bus.offset = v.off;
  endtask
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    if (!v.st) chk({tag, " pc_next"}, 32'(bus.pc_next), 32'(v.pc));
    @(posedge clk);
    #1;
    chk({tag, " pc"}, 32'(bus.pc_current), 32'(v.pc));
    chk({tag, " count"}, 32'(bus.ras_count), 32'(v.cnt));
    chk({tag, " ovf"}, 32'(bus.ras_overflow), 32'(v.ovf));
    chk({tag, " unf"}, 32'(bus.ras_underflow), 32'(v.unf));
  endtask
  initial begin
    //        st r c j bq bn z clr  tgt      off      pc       cnt ovf unf
    t1.push_back(mk(0,0,0,0,0,0,0,0, 0,       0,       1,       0,0,0));
    t1.push_back(mk(0,0,0,0,0,0,0,0, 0,       0,       2,       0,0,0));
    t1.push_back(mk(0,0,0,0,0,0,0,0, 0,       0,       3,       0,0,0));
    t1.push_back(mk(0,0,0,1,0,0,0,0, 'h7FFFF, 0,       'h7FFFF, 0,0,0));
    t1.push_back(mk(0,0,0,0,0,0,0,0, 0,       0,       0,       0,0,0));
    t1.push_back(mk(0,0,0,1,0,0,0,0, 10,      0,       10,      0,0,0));
    t1.push_back(mk(0,0,1,0,0,0,0,0, 100,     0,       100,     1,0,0));
    t1.push_back(mk(0,1,0,0,0,0,0,0, 0,       0,       11,      0,0,0));
    t1.push_back(mk(0,1,0,0,0,0,0,0, 0,       0,       12,      0,0,1));
    t1.push_back(mk(0,0,0,0,0,0,0,1, 0,       0,       13,      0,0,0));
    t1.push_back(mk(0,0,0,1,0,0,0,0, 20,      0,       20,      0,0,0));
    t1.push_back(mk(0,0,0,0,1,0,1,0, 0,       'h7FFFB, 16,      0,0,0));
    t1.push_back(mk(0,0,0,1,0,0,0,0, 20,      0,       20,      0,0,0));
    t1.push_back(mk(0,0,0,0,1,0,0,0, 0,       'h7FFFB, 21,      0,0,0));
    t1.push_back(mk(0,0,0,0,0,1,0,0, 0,       4,       26,      0,0,0));
    t1.push_back(mk(0,0,0,0,0,1,1,0, 0,       4,       27,      0,0,0));
    t1.push_back(mk(0,0,1,0,0,0,0,0, 200,     0,       200,     1,0,0));
    t1.push_back(mk(0,0,1,0,0,0,0,0, 300,     0,       300,     2,0,0));
    t1.push_back(mk(0,1,1,1,0,0,0,0, 555,     0,       201,     1,0,0));
    t1.push_back(mk(0,1,0,0,0,0,0,0, 0,       0,       28,      0,0,0));
    t1.push_back(mk(0,1,0,0,0,0,0,0, 0,       0,       29,      0,0,1));
    t1.push_back(mk(1,0,1,0,0,0,0,0, 400,     0,       29,      0,0,1));
    t1.push_back(mk(1,0,1,0,0,0,0,0, 400,     0,       29,      0,0,1));
    t1.push_back(mk(1,0,1,0,0,0,0,1, 400,     0,       29,      0,0,1));
    t1.push_back(mk(0,0,0,0,0,0,0,1, 0,       0,       30,      0,0,0));
    t1.push_back(mk(0,0,0,0,1,0,1,0, 0,       'h7FFD8, 'h7FFF7, 0,0,0));
    t1.push_back(mk(0,0,0,0,0,1,0,0, 0,       10,      2,       0,0,0));
    t1.push_back(mk(0,1,0,0,0,0,0,1, 0,       0,       3,       0,0,1));
    t1.push_back(mk(0,0,0,0,0,0,0,1, 0,       0,       4,       0,0,0));
    t1.push_back(mk(0,0,1,0,0,0,0,0, 500,     0,       500,     1,0,0));
    t1.push_back(mk(0,0,0,1,1,0,1,0, 600,     4,       600,     1,0,0));
    t2.push_back(mk(0,0,1,0,0,0,0,0, 10,      0,       10,      1,0,0));
    t2.push_back(mk(0,0,1,0,0,0,0,0, 20,      0,       20,      2,0,0));
    t2.push_back(mk(0,0,1,0,0,0,0,0, 30,      0,       30,      3,0,0));
    t2.push_back(mk(0,0,1,0,0,0,0,0, 40,      0,       40,      4,0,0));
    t2.push_back(mk(0,0,1,0,0,0,0,0, 50,      0,       50,      4,1,0));
    t2.push_back(mk(0,1,0,0,0,0,0,0, 0,       0,       WRAP ? 41 : 31, 3,1,0));
    t2.push_back(mk(0,1,0,0,0,0,0,0, 0,       0,       WRAP ? 31 : 21, 2,1,0));
    t2.push_back(mk(0,1,0,0,0,0,0,0, 0,       0,       WRAP ? 21 : 11, 1,1,0));
    t2.push_back(mk(0,1,0,0,0,0,0,0, 0,       0,       WRAP ? 11 : 1,  0,1,0));
    t2.push_back(mk(0,1,0,0,0,0,0,0, 0,       0,       WRAP ? 12 : 2,  0,1,1));
    t2.push_back(mk(0,0,0,0,0,0,0,1, 0,       0,       WRAP ? 13 : 3,  0,0,0));
    drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    #1;
    chk("reset pc", 32'(bus.pc_current), 32'd0);
    chk("reset count", 32'(bus.ras_count), 32'd0);
    chk("reset flags", {30'd0, bus.ras_overflow, bus.ras_underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (t1[i]) apply(t1[i], $sformatf("t1[%0d]", i));
    drive(mk(1,0,1,0,0,0,0,0, 77,0,0,0,0,0));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst pc", 32'(bus.pc_current), 32'd0);
    chk("async rst count", 32'(bus.ras_count), 32'd0);
    @(posedge clk);
    #1;
    chk("held rst pc", 32'(bus.pc_current), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (t2[i]) apply(t2[i], $sformatf("t2[%0d]", i));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
